// File: rtl/rot_ctrl.sv
// rot_ctrl: register-programmed run controller for the rotation core's
// address/set sequencer.
//
// Software programs image size, direction and degrees over an APB-style slave
// (no wait states) and writes START. The controller validates the request,
// launches the core with a one-cycle start pulse, counts completed 8x8 pixel
// sets against the expected total and reports busy/done/error/timeout status
// plus a level interrupt.
//
// Optional feature: define ROT_CTRL_TIMEOUT_EN to build the run watchdog
// (TIMEOUT_W bits wide). Without it STATUS[3] reads 0 and O_ABORT is tied 0.
//
// Ports:
//   I_HCLK, I_HRESET_N             clock, synchronous active-low reset
//   I_PSEL/I_PENABLE/I_PWRITE      APB control
//   I_PADDR[3:0], I_PWDATA[31:0]   APB address / write data
//   O_PRDATA[31:0]                 APB read data (0 unless PSEL & !PWRITE)
//   O_START                        one-cycle launch pulse to the core
//   O_HEIGHT/O_WIDTH[15:0]         shadow image size
//   O_DIRECTION, O_DEGREES[2:0]    shadow rotation setup
//   O_ABORT                        one-cycle pulse on watchdog timeout
//   O_IRQ                          IRQ_EN & (DONE | ERR | TMO)
//   I_CORE_BUSY                    core activity level
//   I_SET_DONE                     one pulse per completed 64-beat set
//
// Register map ([3:2] of I_PADDR):
//   0x0 CTRL   [0] START (W1, reads 0), [1] DIRECTION, [4:2] DEGREES, [8] IRQ_EN
//   0x4 SIZE   [15:0] WIDTH, [31:16] HEIGHT
//   0x8 STATUS [0] BUSY, [1] DONE, [2] ERR, [3] TMO (W1C), [31:8] SETS
//   0xC TOTAL  [23:0] expected sets

module rot_ctrl #(
  parameter int unsigned TIMEOUT_W = 20
) (
  input  logic        I_HCLK,
  input  logic        I_HRESET_N,
  input  logic        I_PSEL,
  input  logic        I_PENABLE,
  input  logic        I_PWRITE,
  input  logic [3:0]  I_PADDR,
  input  logic [31:0] I_PWDATA,
  output logic [31:0] O_PRDATA,
  output logic        O_START,
  output logic [15:0] O_HEIGHT,
  output logic [15:0] O_WIDTH,
  output logic        O_DIRECTION,
  output logic [2:0]  O_DEGREES,
  output logic        O_ABORT,
  output logic        O_IRQ,
  input  logic        I_CORE_BUSY,
  input  logic        I_SET_DONE
);

  typedef enum logic [2:0] {
    StIdle,
    StCheck,
    StLaunch,
    StRun,
    StDone
  } state_e;

  state_e state_q, state_d;

  // Programmable registers
  logic        dir_q, dir_d;
  logic [2:0]  deg_q, deg_d;
  logic        irq_en_q, irq_en_d;
  logic [15:0] width_q, width_d;
  logic [15:0] height_q, height_d;

  // Shadow copies presented to the core
  logic [15:0] sh_height_q, sh_height_d;
  logic [15:0] sh_width_q, sh_width_d;
  logic        sh_dir_q, sh_dir_d;
  logic [2:0]  sh_deg_q, sh_deg_d;

  // Status / progress
  logic        done_q, done_d;
  logic        err_q, err_d;
  logic [23:0] sets_q, sets_d;
  logic [23:0] total_q, total_d;
  logic        first_q, first_d;
  logic        tmo_bit;

  logic        busy;
  logic        apb_wr;
  logic        wr_ctrl, wr_size, wr_status;
  logic        start_req;
  logic        set_err, set_done, set_tmo;
  logic        req_valid;

  logic [16:0] h_sum, w_sum;
  logic [24:0] total_full;

  assign busy      = (state_q != StIdle);
  assign apb_wr    = I_PSEL & I_PENABLE & I_PWRITE;
  assign wr_ctrl   = apb_wr & (I_PADDR[3:2] == 2'd0);
  assign wr_size   = apb_wr & (I_PADDR[3:2] == 2'd1);
  assign wr_status = apb_wr & (I_PADDR[3:2] == 2'd2);
  assign start_req = wr_ctrl & I_PWDATA[0] & ~busy;

  // Set count per axis is ceil(x/8); legal sizes keep the product within 24 bits.
  assign h_sum      = {1'b0, sh_height_q} + 17'd7;
  assign w_sum      = {1'b0, sh_width_q} + 17'd7;
  assign total_full = 25'(h_sum[15:3]) * 25'(w_sum[14:3]);

  assign req_valid = (sh_height_q != 16'd0) && (sh_width_q != 16'd0) &&
                     !sh_height_q[15] && (sh_width_q[15:14] == 2'b00) &&
                     (sh_deg_q <= 3'd3);

  // Register writes: size and rotation fields are frozen while busy.
  always_comb begin
    dir_d       = dir_q;
    deg_d       = deg_q;
    irq_en_d    = irq_en_q;
    width_d     = width_q;
    height_d    = height_q;
    sh_height_d = sh_height_q;
    sh_width_d  = sh_width_q;
    sh_dir_d    = sh_dir_q;
    sh_deg_d    = sh_deg_q;

    if (wr_ctrl) begin
      irq_en_d = I_PWDATA[8];
      if (!busy) begin
        dir_d = I_PWDATA[1];
        deg_d = I_PWDATA[4:2];
      end
    end
    if (wr_size && !busy) begin
      width_d  = I_PWDATA[15:0];
      height_d = I_PWDATA[31:16];
    end
    // Shadows take the rotation fields from the START write itself so a single
    // CTRL write can both configure and launch.
    if (start_req) begin
      sh_height_d = height_q;
      sh_width_d  = width_q;
      sh_dir_d    = I_PWDATA[1];
      sh_deg_d    = I_PWDATA[4:2];
    end
  end

  // Optional run watchdog
`ifdef ROT_CTRL_TIMEOUT_EN
  logic [TIMEOUT_W-1:0] wdog_q, wdog_d;
  logic                 tmo_q, tmo_d;
  logic                 wdog_expired;

  assign wdog_expired = (state_q == StRun) && (&wdog_q);

  always_comb begin
    wdog_d = wdog_q;
    if (state_q == StLaunch) begin
      wdog_d = '0;
    end else if (state_q == StRun) begin
      wdog_d = I_SET_DONE ? '0 : wdog_q + 1'b1;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (start_req) begin
      tmo_d = 1'b0;
    end else begin
      tmo_d = (tmo_q & ~(wr_status & I_PWDATA[3])) | set_tmo;
    end
  end

  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      wdog_q <= '0;
      tmo_q  <= 1'b0;
    end else begin
      wdog_q <= wdog_d;
      tmo_q  <= tmo_d;
    end
  end

  assign tmo_bit = tmo_q;
`else
  logic wdog_expired;
  logic unused_timeout_cfg;

  assign wdog_expired       = 1'b0;
  assign tmo_bit            = 1'b0;
  assign unused_timeout_cfg = (TIMEOUT_W != 0);
`endif

  // FSM next state and status updates
  always_comb begin
    state_d  = state_q;
    sets_d   = sets_q;
    total_d  = total_q;
    set_err  = 1'b0;
    set_done = 1'b0;
    set_tmo  = 1'b0;
    O_START  = 1'b0;
    O_ABORT  = 1'b0;
    first_d  = (state_q == StLaunch);

    unique case (state_q)
      StIdle: begin
        if (start_req) begin
          sets_d  = '0;
          state_d = StCheck;
        end
      end
      StCheck: begin
        total_d = total_full[23:0];
        if (req_valid) begin
          state_d = StLaunch;
        end else begin
          set_err = 1'b1;
          state_d = StIdle;
        end
      end
      StLaunch: begin
        O_START = 1'b1;
        state_d = StRun;
      end
      StRun: begin
        if (I_SET_DONE && (sets_q < total_q)) begin
          sets_d = sets_q + 24'd1;
        end
        if ((sets_q == total_q) && !I_CORE_BUSY) begin
          state_d = StDone;
        end else if (!I_CORE_BUSY && !first_q) begin
          // Core went idle before delivering every set.
          set_err = 1'b1;
          state_d = StIdle;
        end else if (wdog_expired) begin
          set_tmo = 1'b1;
          O_ABORT = 1'b1;
          state_d = StIdle;
        end
      end
      StDone: begin
        set_done = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // W1C flags: a hardware set in the same cycle as a clear wins.
  always_comb begin
    if (start_req) begin
      done_d = 1'b0;
      err_d  = 1'b0;
    end else begin
      done_d = (done_q & ~(wr_status & I_PWDATA[1])) | set_done;
      err_d  = (err_q & ~(wr_status & I_PWDATA[2])) | set_err;
    end
  end

  always_ff @(posedge I_HCLK) begin
    if (!I_HRESET_N) begin
      state_q     <= StIdle;
      dir_q       <= 1'b0;
      deg_q       <= 3'd0;
      irq_en_q    <= 1'b0;
      width_q     <= 16'd0;
      height_q    <= 16'd0;
      sh_height_q <= 16'd0;
      sh_width_q  <= 16'd0;
      sh_dir_q    <= 1'b0;
      sh_deg_q    <= 3'd0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
      sets_q      <= 24'd0;
      total_q     <= 24'd0;
      first_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      dir_q       <= dir_d;
      deg_q       <= deg_d;
      irq_en_q    <= irq_en_d;
      width_q     <= width_d;
      height_q    <= height_d;
      sh_height_q <= sh_height_d;
      sh_width_q  <= sh_width_d;
      sh_dir_q    <= sh_dir_d;
      sh_deg_q    <= sh_deg_d;
      done_q      <= done_d;
      err_q       <= err_d;
      sets_q      <= sets_d;
      total_q     <= total_d;
      first_q     <= first_d;
    end
  end

  // Read mux
  always_comb begin
    O_PRDATA = 32'd0;
    if (I_PSEL && !I_PWRITE) begin
      unique case (I_PADDR[3:2])
        2'd0: O_PRDATA = {23'd0, irq_en_q, 3'd0, deg_q, dir_q, 1'b0};
        2'd1: O_PRDATA = {height_q, width_q};
        2'd2: O_PRDATA = {sets_q, 4'd0, tmo_bit, err_q, done_q, busy};
        2'd3: O_PRDATA = {8'd0, total_q};
        default: O_PRDATA = 32'd0;
      endcase
    end
  end

  assign O_HEIGHT    = sh_height_q;
  assign O_WIDTH     = sh_width_q;
  assign O_DIRECTION = sh_dir_q;
  assign O_DEGREES   = sh_deg_q;
  assign O_IRQ       = irq_en_q & (done_q | err_q | tmo_bit);

  logic unused_bits;
  assign unused_bits = ^{I_PADDR[1:0], h_sum[16], h_sum[2:0], w_sum[16:15], w_sum[2:0],
                         total_full[24]};

endmodule

// File: tb/tb_rot_ctrl.sv
module tb_rot_ctrl;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        psel, penable, pwrite;
  logic [3:0]  paddr;
  logic [31:0] pwdata, prdata;
  logic        o_start, o_dir, o_abort, o_irq;
  logic [15:0] o_height, o_width;
  logic [2:0]  o_deg;
  logic        core_busy, set_done;

  always #5 clk = ~clk;

  rot_ctrl #(.TIMEOUT_W(4)) dut (
    .I_HCLK      (clk),
    .I_HRESET_N  (rst_n),
    .I_PSEL      (psel),
    .I_PENABLE   (penable),
    .I_PWRITE    (pwrite),
    .I_PADDR     (paddr),
    .I_PWDATA    (pwdata),
    .O_PRDATA    (prdata),
    .O_START     (o_start),
    .O_HEIGHT    (o_height),
    .O_WIDTH     (o_width),
    .O_DIRECTION (o_dir),
    .O_DEGREES   (o_deg),
    .O_ABORT     (o_abort),
    .O_IRQ       (o_irq),
    .I_CORE_BUSY (core_busy),
    .I_SET_DONE  (set_done)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int start_cnt = 0;
  int abort_cnt = 0;

  always @(negedge clk) begin
    if (o_start) start_cnt++;
    if (o_abort) abort_cnt++;
  end

  typedef struct {
    logic [15:0] h;
    logic [15:0] w;
    bit          valid;
    logic [23:0] total;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = a; pwdata = d;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d);
    @(posedge clk); #1;
    psel = 1'b1; pwrite = 1'b0; penable = 1'b0; paddr = a;
    @(posedge clk); #1;
    penable = 1'b1;
    #2 d = prdata;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  task automatic pulse_set();
    @(posedge clk); #1;
    set_done = 1'b1;
    @(posedge clk); #1;
    set_done = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_timeout: got running, expected finished");
    $fatal(1, "simulation time limit");
  end

  initial begin
    logic [31:0] rd;
    int s0, a0;

    vecs[0] = '{h: 16'd16,    w: 16'd24,    valid: 1'b1, total: 24'd6};
    vecs[1] = '{h: 16'd10,    w: 16'd9,     valid: 1'b1, total: 24'd4};
    vecs[2] = '{h: 16'd8,     w: 16'd8,     valid: 1'b1, total: 24'd1};
    vecs[3] = '{h: 16'd1,     w: 16'd1,     valid: 1'b1, total: 24'd1};
    vecs[4] = '{h: 16'h7fff,  w: 16'h3fff,  valid: 1'b1, total: 24'h800000};
    vecs[5] = '{h: 16'd0,     w: 16'd8,     valid: 1'b0, total: 24'd0};
    vecs[6] = '{h: 16'h8000,  w: 16'd8,     valid: 1'b0, total: 24'd0};
    vecs[7] = '{h: 16'd8,     w: 16'h4000,  valid: 1'b0, total: 24'd0};
    vecs[8] = '{h: 16'd8,     w: 16'd0,     valid: 1'b0, total: 24'd0};

    rst_n = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = 4'd0; pwdata = 32'd0; core_busy = 1'b0; set_done = 1'b0;
    cyc(3);
    rst_n = 1'b1;
    cyc(1);

    // Reset state
    check("rst_start", {31'd0, o_start}, 32'd0);
    check("rst_irq", {31'd0, o_irq}, 32'd0);
    check("rst_abort", {31'd0, o_abort}, 32'd0);
    check("rst_shadow", {o_height, o_width}, 32'd0);
    check("rst_dirdeg", {28'd0, o_dir, o_deg}, 32'd0);
    check("rst_prdata_idle", prdata, 32'd0);
    for (int i = 0; i < 4; i++) begin
      apb_read(4'(i * 4), rd);
      check($sformatf("rst_reg%0d", i), rd, 32'd0);
    end

    // Main run: H=16 W=24, DIR=1 DEG=1 IRQ_EN=1
    core_busy = 1'b1;
    s0 = start_cnt;
    apb_write(4'h4, {16'd16, 16'd24});
    apb_write(4'h0, 32'h107);
    check("main_n1_start", {31'd0, o_start}, 32'd0);
    check("main_shadow_size", {o_height, o_width}, {16'd16, 16'd24});
    check("main_shadow_dirdeg", {28'd0, o_dir, o_deg}, 32'h9);
    cyc(1);
    check("main_n2_start", {31'd0, o_start}, 32'd1);
    cyc(1);
    check("main_n3_start", {31'd0, o_start}, 32'd0);
    apb_read(4'hC, rd);
    check("main_total", rd, 32'd6);
    apb_read(4'h8, rd);
    check("main_status_busy", rd, 32'h1);
    apb_write(4'h4, 32'd0);
    apb_read(4'h4, rd);
    check("main_size_frozen", rd, {16'd16, 16'd24});
    apb_write(4'h0, 32'h101);
    apb_read(4'h0, rd);
    check("main_ctrl_frozen", rd, 32'h106);
    for (int i = 0; i < 7; i++) pulse_set();
    apb_read(4'h8, rd);
    check("main_sets_saturate", rd, 32'h601);
    check("main_single_start", 32'(start_cnt - s0), 32'd1);
    @(posedge clk); #1;
    core_busy = 1'b0;
    check("main_irq_c0", {31'd0, o_irq}, 32'd0);
    cyc(1);
    check("main_irq_c1", {31'd0, o_irq}, 32'd0);
    cyc(1);
    check("main_irq_c2", {31'd0, o_irq}, 32'd1);
    apb_read(4'h8, rd);
    check("main_status_done", rd, 32'h602);

    // Table of sizes: valid ones launch and then error on idle core, invalid ones never launch
    for (int i = 0; i < 9; i++) begin
      core_busy = 1'b0;
      s0 = start_cnt;
      apb_write(4'h4, {vecs[i].h, vecs[i].w});
      apb_write(4'h0, 32'h101);
      cyc(6);
      if (vecs[i].valid) begin
        apb_read(4'hC, rd);
        check($sformatf("vec%0d_total", i), rd, {8'd0, vecs[i].total});
      end
      apb_read(4'h8, rd);
      check($sformatf("vec%0d_status", i), rd, 32'h4);
      check($sformatf("vec%0d_starts", i), 32'(start_cnt - s0), vecs[i].valid ? 32'd1 : 32'd0);
      apb_write(4'h8, 32'h4);
    end

    // DONE set and W1C in the same cycle: set wins
    core_busy = 1'b1;
    apb_write(4'h4, {16'd8, 16'd8});
    apb_write(4'h0, 32'h101);
    cyc(2);
    pulse_set();
    cyc(1);
    @(posedge clk); #1;
    core_busy = 1'b0;
    psel = 1'b1; pwrite = 1'b1; penable = 1'b0; paddr = 4'h8; pwdata = 32'h2;
    @(posedge clk); #1;
    penable = 1'b1;
    @(posedge clk); #1;
    psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    apb_read(4'h8, rd);
    check("w1c_race_done", rd, 32'h102);
    apb_write(4'h8, 32'h2);
    apb_read(4'h8, rd);
    check("w1c_done_clear", rd, 32'h100);

    // Core goes idle after 3 of 6 sets
    core_busy = 1'b1;
    apb_write(4'h4, {16'd16, 16'd24});
    apb_write(4'h0, 32'h101);
    cyc(2);
    for (int i = 0; i < 3; i++) pulse_set();
    @(posedge clk); #1;
    core_busy = 1'b0;
    cyc(3);
    apb_read(4'h8, rd);
    check("early_idle_status", rd, 32'h304);
    check("early_idle_irq", {31'd0, o_irq}, 32'd1);

    // Invalid DEGREES=5: ERR at N+2, no launch, W1C clears
    s0 = start_cnt;
    apb_write(4'h4, {16'd8, 16'd8});
    apb_write(4'h0, 32'h115);
    check("deg5_irq_n1", {31'd0, o_irq}, 32'd0);
    cyc(1);
    check("deg5_irq_n2", {31'd0, o_irq}, 32'd1);
    check("deg5_start_n2", {31'd0, o_start}, 32'd0);
    cyc(2);
    check("deg5_no_start", 32'(start_cnt - s0), 32'd0);
    apb_read(4'h8, rd);
    check("deg5_status", rd, 32'h4);
    apb_write(4'h8, 32'h4);
    check("deg5_irq_cleared", {31'd0, o_irq}, 32'd0);
    apb_read(4'h8, rd);
    check("deg5_status_cleared", rd, 32'h0);

    // No set progress with the core still busy
    core_busy = 1'b1;
    a0 = abort_cnt;
    apb_write(4'h4, {16'd8, 16'd8});
    apb_write(4'h0, 32'h101);
    cyc(25);
    apb_read(4'h8, rd);
`ifdef ROT_CTRL_TIMEOUT_EN
    check("stall_status", rd, 32'h8);
    check("stall_aborts", 32'(abort_cnt - a0), 32'd1);
    check("stall_irq", {31'd0, o_irq}, 32'd1);
`else
    check("stall_status", rd, 32'h1);
    check("stall_aborts", 32'(abort_cnt - a0), 32'd0);
    check("stall_irq", {31'd0, o_irq}, 32'd0);
`endif
    core_busy = 1'b0;
    cyc(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/rot_ctrl.md
# rot_ctrl

Register-programmed run controller for the rotation core's address/set sequencer. It exposes an APB-style slave for software to program image size, direction and degrees. It validates the request, launches the core with a start pulse, and counts completed 8x8 pixel sets against the expected total. It reports busy/done/error/timeout status and raises an interrupt. It sits between the system register bus and the core.

## Interface
- TIMEOUT_W, 20: watchdog counter width; timeout fires after 2^TIMEOUT_W−1 cycles without set progress (used only with ROT_CTRL_TIMEOUT_EN).
- I_HCLK  in  1  clock; all logic on rising edge.
- I_HRESET_N  in  1  reset; synchronous, active-low.
- I_PSEL, I_PENABLE, I_PWRITE  in  1 each  APB control; access completes in the access phase (PSEL & PENABLE), no wait states.
- I_PADDR  in  4  byte address; [3:2] selects register.
- I_PWDATA  in  32  write data.
- O_PRDATA  out  32  read data; combinational from registers when PSEL & !PWRITE, else 0.
- O_START  out  1  one-cycle launch pulse to the core.
- O_HEIGHT, O_WIDTH  out  16 each  shadow size; held stable from CHECK until the next start.
- O_DIRECTION  out  1  shadow direction.
- O_DEGREES  out  3  shadow degrees code (0..3).
- O_ABORT  out  1  one-cycle pulse on timeout; tied 0 without ROT_CTRL_TIMEOUT_EN.
- O_IRQ  out  1  level: IRQ_EN & (DONE | ERR | TMO).
- I_CORE_BUSY  in  1  core activity level.
- I_SET_DONE  in  1  one-cycle pulse per completed 64-beat set write.

## Operation
- Registers:
  - 0x0 CTRL: [0] START (write-1, self-clearing, reads 0), [1] DIRECTION, [4:2] DEGREES, [8] IRQ_EN.
  - 0x4 SIZE: [15:0] WIDTH, [31:16] HEIGHT.
  - 0x8 STATUS: [0] BUSY (RO), [1] DONE, [2] ERR, [3] TMO (all W1C), [31:8] SETS completed (RO).
  - 0xC TOTAL (RO): [23:0] expected sets.
- While BUSY, writes to SIZE and CTRL[4:1] are ignored; IRQ_EN is always writable; START is ignored.
- FSM IDLE → CHECK → LAUNCH → RUN → DONE → IDLE.
  - IDLE: START=1 write moves to CHECK. Shadows latch; SETS, DONE, ERR and TMO clear.
  - CHECK (1 cycle): TOTAL = ceil(H/8) × ceil(W/8), 24-bit. Reject if H==0, W==0, H[15]=1, W[15:14]≠0, or DEGREES>3: set ERR, go IDLE, no O_START.
  - LAUNCH (1 cycle): O_START=1.
  - RUN:
    - Each I_SET_DONE increments SETS; SETS saturates at TOTAL and extra pulses are ignored.
    - SETS==TOTAL and !I_CORE_BUSY → DONE.
    - I_CORE_BUSY low with SETS<TOTAL (after the first cycle of RUN) → set ERR, go IDLE.
  - DONE (1 cycle): set DONE, go IDLE.
- A W1C clear and a hardware set of the same flag in the same cycle: set wins.
- Reset mid-run: FSM → IDLE and all registers/outputs → 0. No O_ABORT is issued; the core is reset by the same reset.

## Timing
- Reset values: O_PRDATA=0, O_START=0, O_HEIGHT=0, O_WIDTH=0, O_DIRECTION=0, O_DEGREES=0, O_ABORT=0, O_IRQ=0. All registers 0.
- START written in access cycle N:
  - CHECK at N+1; BUSY reads 1 from N+1.
  - O_START high in cycle N+2 only.
- I_SET_DONE in cycle M: SETS updated and visible at M+1.
- DONE state entered in the cycle after the completion condition holds. DONE flag and O_IRQ rise one cycle after that; BUSY falls in the same cycle.
- ERR from CHECK: ERR and O_IRQ visible at N+2; O_START never pulses.

## Configuration
- ROT_CTRL_TIMEOUT_EN defined:
  - TIMEOUT_W-bit watchdog counts in RUN and clears on I_SET_DONE and on LAUNCH.
  - At all-ones: set TMO, pulse O_ABORT one cycle, go IDLE.
- ROT_CTRL_TIMEOUT_EN undefined: no watchdog logic; STATUS[3] reads 0; O_ABORT constant 0.

## Test plan
- Reset, then read all four registers → all 0; O_START=0, O_IRQ=0.
- SIZE H=16 W=24, CTRL DIR=1 DEG=1 IRQ_EN=1 START; feed 6 I_SET_DONE pulses, then drop busy:
  - TOTAL reads 6; O_START pulses once at N+2.
  - DONE=1, SETS=6, O_IRQ=1.
- H=10 W=9 → TOTAL=4. Write SIZE mid-run → ignored. Write START mid-run → no second O_START.
- Invalid H=0x8000 or DEGREES=5 → ERR=1 at N+2, no O_START; W1C STATUS 0x4 clears ERR and O_IRQ drops.
- Busy drops after 3 of 6 sets → ERR=1, BUSY=0. Simultaneous W1C of DONE and a DONE set → DONE stays 1.
- With ROT_CTRL_TIMEOUT_EN, TIMEOUT_W=4: no set pulses for 15 cycles → TMO=1, one-cycle O_ABORT. Without the macro, the same stimulus → no TMO, controller stays in RUN.
